// File: rtl/vram_arbiter.sv
// Tile-RAM arbiter: shares one single-port tile RAM between the pixel renderer
// (fixed priority, fetches one tile per 32-pixel cell) and a game-logic port.
module vram_arbiter #(
  parameter bit LOGIC_VBLANK_ONLY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       display_on,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       lg_req,
  input  logic       lg_we,
  input  logic [8:0] lg_addr,
  input  logic [7:0] lg_wdata,
  output logic       lg_gnt,
  output logic       lg_rvalid,
  output logic [7:0] lg_rdata,
  output logic       ram_en,
  output logic       ram_we,
  output logic [8:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [7:0] tile_id,
  output logic       frame_start,
  output logic       vblank
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LG_ACC  = 2'd1,
    LG_RESP = 2'd2
  } lg_state_t;

  lg_state_t  state, state_next;
  logic [8:0] tile_addr;
  logic       render_req;
  logic       lg_start;
  logic       acc_we;
  logic       rd_p1;
  logic       rd_p2;

  assign vblank     = (y_pos >= 10'd480);
  assign tile_addr  = 9'(y_pos[9:5]) * 9'd20 + 9'(x_pos[9:5]);
  assign render_req = p_tick && display_on && (x_pos[4:0] == 5'd0);

  // Logic may only start from IDLE and always yields to a same-cycle render fetch.
  assign lg_start = (state == IDLE) && lg_req && !render_req
                    && (!LOGIC_VBLANK_ONLY || vblank);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (lg_start) state_next = LG_ACC;
      LG_ACC:  state_next = LG_RESP;
      LG_RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      acc_we      <= 1'b0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      tile_id     <= '0;
      frame_start <= 1'b0;
    end else begin
      state  <= state_next;
      ram_en <= render_req || lg_start;
      ram_we <= lg_start && lg_we;
      if (render_req) begin
        ram_addr  <= tile_addr;
        ram_wdata <= '0;
      end else if (lg_start) begin
        ram_addr  <= lg_addr;
        ram_wdata <= lg_wdata;
      end
      if (lg_start) acc_we <= lg_we;
      // Render read: command in N+1, data in N+2, captured into tile_id for N+3.
      rd_p1 <= render_req;
      rd_p2 <= rd_p1;
      if (rd_p2) tile_id <= ram_rdata;
      frame_start <= p_tick && (x_pos == 10'd799) && (y_pos == 10'd520);
    end
  end

  assign lg_gnt    = (state == LG_ACC);
  assign lg_rvalid = (state == LG_RESP) && !acc_we;
  assign lg_rdata  = lg_rvalid ? ram_rdata : 8'h00;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter LOGIC_VBLANK_ONLY, default 0; when 1, logic accesses are granted only while vblank=1.
REQ-002 The block SHALL have port clk  input  1  system clock, 100 MHz; the single clock for all logic.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port p_tick  input  1  pixel-enable strobe, high one clk in four.
REQ-005 The block SHALL have port display_on  input  1  visible-area flag.
REQ-006 The block SHALL have ports x_pos and y_pos  input  10 each  pixel column 0..799 and pixel row 0..520.
REQ-007 The block SHALL have port lg_req  input  1  game-logic access request.
REQ-008 The block SHALL have ports lg_we (input, 1), lg_addr (input, 9) and lg_wdata (input, 8)  logic write-enable, tile address and write data.
REQ-009 The block SHALL have port lg_gnt  output  1  one-clk grant pulse.
REQ-010 The block SHALL have ports lg_rvalid (output, 1) and lg_rdata (output, 8)  logic read response.
REQ-011 The block SHALL have ports ram_en, ram_we (output, 1 each), ram_addr (output, 9) and ram_wdata (output, 8)  registered single-port tile-RAM command.
REQ-012 The block SHALL have port ram_rdata  input  8  RAM read data, valid 1 clk after its command.
REQ-013 The block SHALL have port tile_id  output  8  tile under the current 32x32 pixel cell.
REQ-014 The block SHALL have ports frame_start (output, 1, one-clk pulse) and vblank (output, 1, y_pos>=480).

Function
REQ-015 The tile address SHALL be (y_pos>>5)*20 + (x_pos>>5), range 0..299, computed in 9 bits.
REQ-016 A render fetch SHALL be requested in clk cycle N when p_tick=1, display_on=1 and x_pos[4:0]=0.
REQ-017 Every arbitration decision made in cycle N SHALL drive ram_en/ram_we/ram_addr/ram_wdata in cycle N+1; if there is no decision, ram_en=0 and ram_we=0.
REQ-018 A render read's ram_rdata SHALL arrive in N+2 and SHALL be registered into tile_id in N+3; tile_id SHALL hold its value otherwise.
REQ-019 The logic FSM SHALL have states IDLE, LG_ACC and LG_RESP.
REQ-020 IDLE->LG_ACC SHALL occur when lg_req=1, no render fetch is requested that cycle, and (LOGIC_VBLANK_ONLY=0 or vblank=1).
REQ-021 LG_ACC SHALL go to LG_RESP unconditionally; LG_RESP SHALL go to IDLE unconditionally.
REQ-022 In LG_ACC, lg_gnt SHALL be 1 and the RAM command SHALL carry lg_we/lg_addr/lg_wdata as sampled at the decision cycle.
REQ-023 In LG_RESP, lg_rvalid SHALL be 1 and lg_rdata SHALL equal ram_rdata if the access was a read; for writes, lg_rvalid SHALL be 0.
REQ-024 lg_req SHALL be ignored in LG_ACC and LG_RESP; the logic port therefore accepts at most one access per 3 clks.
REQ-025 The requester SHALL hold lg_req, lg_we, lg_addr and lg_wdata stable until it sees lg_gnt; it may deassert or change them in the lg_gnt cycle.
REQ-026 If a render fetch and lg_req occur in the same cycle, render SHALL win, lg_gnt SHALL stay 0, and the request SHALL be retried the next cycle.
REQ-027 A render decision SHALL be able to coincide with LG_ACC or LG_RESP (its RAM cycle follows the logic cycle); RAM commands SHALL never collide, one per clk at most.
REQ-028 lg_addr >= 300 SHALL be passed to the RAM unmodified; the RAM ignores it and this block does not check it.
REQ-029 frame_start SHALL be a registered pulse, 1 in the clk after a cycle with p_tick=1, x_pos=799 and y_pos=520.
REQ-030 vblank SHALL be combinational from y_pos.

Reset
REQ-031 On reset=1 at a clk edge, the FSM SHALL go to IDLE, and ram_en, ram_we, lg_gnt, lg_rvalid and frame_start SHALL be 0.
REQ-032 On reset, ram_addr, ram_wdata, lg_rdata and tile_id SHALL be 0.
REQ-033 On reset mid-transaction, the in-flight access and any pending render capture SHALL be dropped: no lg_rvalid and no tile_id update afterwards.
REQ-034 The first decision after reset release SHALL be possible in the first clk with reset=0.

Verification
REQ-035 The bench SHALL cover render fetch: RAM[21]=0x07; p_tick at x=32, y=32, display_on=1 -> ram_en=1 with addr 21 at N+1, tile_id=0x07 at N+3.
REQ-036 The bench SHALL cover collision: lg_req read addr 5 in the same cycle as a render fetch at x=0, y=0 -> ram addr 0 at N+1 with lg_gnt=0; lg_gnt=1 with addr 5 at N+2; lg_rvalid with RAM[5] at N+3.
REQ-037 The bench SHALL cover the write path: lg_req, we=1, addr 299, data 0xA5 during blanking -> ram_we=1 and lg_gnt=1 next clk, no lg_rvalid; a later render at x=608, y=448 gives tile_id=0xA5.
REQ-038 The bench SHALL cover vblank gating: LOGIC_VBLANK_ONLY=1, lg_req held at y=100 -> no lg_gnt until y=480; the grant comes within 1 clk of vblank rising.
REQ-039 The bench SHALL cover back-to-back requests: lg_req held continuously -> lg_gnt pulses exactly every 3 clks absent render conflicts.
REQ-040 The bench SHALL cover reset and frame pulse: reset asserted in LG_ACC of a read -> no lg_rvalid, all outputs 0; frame_start pulses once per 800x521 pixel ticks.
